// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between the fetch (inst)
// port and the MEM-stage data port. Address phases are arbitrated with data
// priority plus a starvation guard for fetch; accepted requests are logged in
// an order FIFO so each returning response is steered back to its issuer.
//
// Handshake semantics: a request is offered while *_req is high and is taken
// in the cycle where the matching *_addr_ok is high (req && addr_ok). A
// response is delivered in the single cycle *_data_ok is high; *_rdata is only
// meaningful in that cycle. Requesters may change or drop a request that has
// not yet seen addr_ok.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  localparam int PW = $clog2(MAX_OUTSTANDING),
  localparam int CW = PW + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  // fetch port
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [3:0]    inst_wstrb,
  input  logic [31:0]   inst_addr,
  input  logic [31:0]   inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  // data port
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [3:0]    data_wstrb,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  // downstream memory port
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [31:0]   mem_rdata,
  // status / debug
  output logic [CW-1:0] outstanding,
  output logic          err_stray_ok,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_INST = 2'd1,
    ST_HOLD_DATA = 2'd2
  } state_e;

  state_e          state_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;   // source bit per slot: 0=inst, 1=data
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [SW-1:0]   starve_q;
  logic            err_q;

  logic            grant_vld;
  logic            grant_data;
  logic            full;
  logic            empty;
  logic            starve_hit;
  logic            handshake;
  logic            pop;
  logic            head_src;

  assign full       = (count_q == CW'(MAX_OUTSTANDING));
  assign empty      = (count_q == '0);
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));

  // Grant selection: a held grant sticks to its source; otherwise data wins
  // unless fetch has been starved for STARVE_LIMIT data grants.
  always_comb begin
    grant_vld  = 1'b0;
    grant_data = 1'b0;
    unique case (state_q)
      ST_HOLD_INST: begin
        grant_vld  = inst_req;
        grant_data = 1'b0;
      end
      ST_HOLD_DATA: begin
        grant_vld  = data_req;
        grant_data = 1'b1;
      end
      default: begin
        if (inst_req && (!data_req || starve_hit)) begin
          grant_vld  = 1'b1;
          grant_data = 1'b0;
        end else if (data_req) begin
          grant_vld  = 1'b1;
          grant_data = 1'b1;
        end
      end
    endcase
  end

  // Downstream request mux follows the grant; a full order FIFO blocks issue.
  always_comb begin
    mem_req   = grant_vld && !full;
    mem_wr    = grant_data ? data_wr    : inst_wr;
    mem_size  = grant_data ? data_size  : inst_size;
    mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    mem_addr  = grant_data ? data_addr  : inst_addr;
    mem_wdata = grant_data ? data_wdata : inst_wdata;
  end

  assign handshake = mem_req && mem_addr_ok;
  assign pop       = mem_data_ok && !empty;
  assign head_src  = fifo_q[rd_ptr_q];

  // Address-phase acks pass straight through to the granted source only.
  always_comb begin
    inst_addr_ok = handshake && !grant_data;
    data_addr_ok = handshake &&  grant_data;
    inst_data_ok = pop && !head_src;
    data_data_ok = pop &&  head_src;
  end

  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = count_q;
  assign err_stray_ok = err_q;
  assign dbg_state    = state_q;

  // Arbitration FSM: hold the grant while the downstream stalls the address
  // phase; release on handshake or when the held source withdraws.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem_req && !mem_addr_ok)
            state_q <= grant_data ? ST_HOLD_DATA : ST_HOLD_INST;
        end
        ST_HOLD_INST: begin
          if (!inst_req || handshake) state_q <= ST_IDLE;
        end
        ST_HOLD_DATA: begin
          if (!data_req || handshake) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Order FIFO: push the source bit on every accepted address phase,
  // pop on every response that has a matching entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (handshake) begin
        fifo_q[wr_ptr_q] <= grant_data;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Occupancy counter with one extra bit so full and empty are distinct.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      unique case ({handshake, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Starvation counter: data grants taken while fetch is waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!inst_req) begin
      starve_q <= '0;
    end else if (handshake && !grant_data) begin
      starve_q <= '0;
    end else if (handshake && grant_data && !starve_hit) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (mem_data_ok && empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbiter.
module tb_sram_req_arbiter;
  localparam int MAXO = 4;
  localparam int SL   = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        err_stray_ok;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit order_q[$];
  int m_starve;
  int m_held;      // 0 none, 1 fetch held, 2 data held
  bit m_err;
  bit m_gvld, m_gdata, m_mem_req, m_iaok, m_daok, m_idok, m_ddok;

  sram_req_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .err_stray_ok(err_stray_ok), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  // advance to just after the next rising edge (input drive point)
  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    drive_idle();
    resetn = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    next_cycle();
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset;
    order_q.delete();
    m_starve = 0; m_held = 0; m_err = 0;
  endtask

  task automatic model_eval;
    bit full;
    full = (order_q.size() == MAXO);
    m_gvld = 0; m_gdata = 0;
    if (m_held == 1) begin m_gvld = inst_req; m_gdata = 0; end
    else if (m_held == 2) begin m_gvld = data_req; m_gdata = 1; end
    else if (inst_req && (!data_req || m_starve == SL)) begin m_gvld = 1; m_gdata = 0; end
    else if (data_req) begin m_gvld = 1; m_gdata = 1; end
    m_mem_req = m_gvld && !full;
    m_iaok = m_mem_req && mem_addr_ok && !m_gdata;
    m_daok = m_mem_req && mem_addr_ok && m_gdata;
    m_idok = mem_data_ok && (order_q.size() > 0) && (order_q[0] == 1'b0);
    m_ddok = mem_data_ok && (order_q.size() > 0) && (order_q[0] == 1'b1);
  endtask

  task automatic model_commit;
    bit hs;
    hs = m_mem_req && mem_addr_ok;
    if (mem_data_ok) begin
      if (order_q.size() > 0) void'(order_q.pop_front());
      else m_err = 1;
    end
    if (hs) order_q.push_back(m_gdata);
    if (!inst_req) m_starve = 0;
    else if (hs && !m_gdata) m_starve = 0;
    else if (hs && m_gdata && m_starve < SL) m_starve++;
    if (!m_gvld) m_held = 0;
    else if (m_mem_req && !mem_addr_ok) m_held = m_gdata ? 2 : 1;
    else if (hs) m_held = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    drive_idle();
    resetn = 0;
    #3;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
    checks++; if (err_stray_ok !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_stray_ok); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      errors++; $display("FAIL reset_oks: got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    @(negedge clk);
    resetn = 1;
    next_cycle();
  endtask

  task automatic test_single;
    inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL single_addr_ok: got i=%b d=%b exp i=1 d=0", inst_addr_ok, data_addr_ok); end
    checks++; if (mem_addr !== 32'h1C000000) begin errors++; $display("FAIL single_mem_addr: got %h exp 1c000000", mem_addr); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h02800000;
    @(negedge clk);
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d exp 1", outstanding); end
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      errors++; $display("FAIL single_data_ok: got i=%b d=%b exp i=1 d=0", inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'h02800000) begin errors++; $display("FAIL single_rdata: got %h exp 02800000", inst_rdata); end
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drain: got %0d exp 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_priority;
    inst_req = 1; inst_addr = 32'h1C000000;
    data_req = 1; data_addr = 32'h1C008000; data_wr = 1; data_wdata = 32'hCAFEF00D;
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      errors++; $display("FAIL prio_c0: got i=%b d=%b exp i=0 d=1", inst_addr_ok, data_addr_ok); end
    checks++; if (mem_addr !== 32'h1C008000 || mem_wr !== 1'b1 || mem_wdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL prio_mux: got addr=%h wr=%b wd=%h exp 1c008000/1/cafef00d", mem_addr, mem_wr, mem_wdata); end
    next_cycle();
    data_req = 0; data_wr = 0;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C000000) begin
      errors++; $display("FAIL prio_c1: got i=%b addr=%h exp 1/1c000000", inst_addr_ok, mem_addr); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
    @(negedge clk);
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h11112222) begin
      errors++; $display("FAIL prio_resp1: got i=%b d=%b rd=%h exp i=0 d=1 11112222", inst_data_ok, data_data_ok, data_rdata); end
    next_cycle();
    mem_rdata = 32'h33334444;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h33334444) begin
      errors++; $display("FAIL prio_resp2: got i=%b d=%b rd=%h exp i=1 d=0 33334444", inst_data_ok, data_data_ok, inst_rdata); end
    next_cycle();
    mem_data_ok = 0;
  endtask

  task automatic test_hold;
    data_req = 1; data_addr = 32'h1C00A000; mem_addr_ok = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C00A000 || data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL hold_c0: got req=%b addr=%h dok=%b exp 1/1c00a000/0", mem_req, mem_addr, data_addr_ok); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      inst_req = 1; inst_addr = 32'h1C000040;
      @(negedge clk);
      checks++; if (dbg_state !== 2'd2 || mem_addr !== 32'h1C00A000 || inst_addr_ok !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d: got st=%0d addr=%h iok=%b exp 2/1c00a000/0", c, dbg_state, mem_addr, inst_addr_ok); end
    end
    next_cycle();
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      errors++; $display("FAIL hold_c3: got i=%b d=%b exp i=0 d=1", inst_addr_ok, data_addr_ok); end
    next_cycle();
    data_req = 0;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C000040) begin
      errors++; $display("FAIL hold_c4: got iok=%b addr=%h exp 1/1c000040", inst_addr_ok, mem_addr); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    next_cycle();
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL hold_drain: got %0d exp 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_full;
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < MAXO; k++) begin
      inst_addr = 32'h1C000000 + 32'(k * 4);
      @(negedge clk);
      checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b exp 1", k, inst_addr_ok); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (outstanding !== 3'd4 || mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_block: got occ=%0d req=%b iok=%b exp 4/0/0", outstanding, mem_req, inst_addr_ok); end
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h0000BEEF;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL full_pop: got idok=%b req=%b exp 1/0", inst_data_ok, mem_req); end
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd3 || mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL full_reopen: got occ=%0d req=%b iok=%b exp 3/1/1", outstanding, mem_req, inst_addr_ok); end
    next_cycle();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < MAXO; k++) next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d exp 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_starve;
    bit prev_inst;
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h1C000100; data_addr = 32'h1C008100;
    prev_inst = 0;
    for (int c = 0; c < 3 * (SL + 1); c++) begin
      mem_data_ok = (c > 0);
      @(negedge clk);
      checks++; if (inst_addr_ok !== ((c % (SL + 1)) == SL) || data_addr_ok !== ((c % (SL + 1)) != SL)) begin
        errors++; $display("FAIL starve_grant c%0d: got i=%b d=%b", c, inst_addr_ok, data_addr_ok); end
      if (c > 0) begin
        checks++; if (inst_data_ok !== prev_inst || data_data_ok !== !prev_inst) begin
          errors++; $display("FAIL starve_resp c%0d: got i=%b d=%b exp i=%b", c, inst_data_ok, data_data_ok, prev_inst); end
      end
      prev_inst = ((c % (SL + 1)) == SL);
      next_cycle();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL starve_drain: got %0d exp 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_stray_reset;
    mem_data_ok = 1;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      errors++; $display("FAIL stray_ok: got i=%b d=%b exp 0/0", inst_data_ok, data_data_ok); end
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (err_stray_ok !== 1'b1) begin errors++; $display("FAIL stray_set: got %b exp 1", err_stray_ok); end
    next_cycle();
    inst_req = 1; mem_addr_ok = 1;
    next_cycle();
    next_cycle();
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    checks++; if (err_stray_ok !== 1'b1 || outstanding !== 3'd2) begin
      errors++; $display("FAIL stray_sticky: got err=%b occ=%0d exp 1/2", err_stray_ok, outstanding); end
    next_cycle();
    #2 resetn = 0;
    #1;
    checks++; if (outstanding !== 3'd0 || err_stray_ok !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL async_reset: got occ=%0d err=%b st=%0d exp 0/0/0", outstanding, err_stray_ok, dbg_state); end
    @(negedge clk);
    resetn = 1;
    next_cycle();
  endtask

  task automatic test_random;
    logic [70:0] exp_bus;
    apply_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 6);
      inst_wr     = $urandom_range(0, 1);
      data_wr     = $urandom_range(0, 1);
      inst_size   = 2'($urandom_range(0, 2));
      data_size   = 2'($urandom_range(0, 2));
      inst_wstrb  = 4'($urandom);
      data_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = ($urandom_range(0, 9) < 6);
      mem_data_ok = ($urandom_range(0, 9) < 5);
      mem_rdata   = $urandom;
      @(negedge clk);
      model_eval();
      checks++; if (mem_req !== m_mem_req) begin errors++; $display("FAIL rnd_mem_req c%0d: got %b exp %b", c, mem_req, m_mem_req); end
      if (m_mem_req) begin
        exp_bus = m_gdata ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                          : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
        checks++; if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== exp_bus) begin
          errors++; $display("FAIL rnd_mux c%0d: got %h exp %h", c, {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_bus); end
      end
      checks++; if ({inst_addr_ok, data_addr_ok} !== {m_iaok, m_daok}) begin
        errors++; $display("FAIL rnd_addr_ok c%0d: got %b%b exp %b%b", c, inst_addr_ok, data_addr_ok, m_iaok, m_daok); end
      checks++; if ({inst_data_ok, data_data_ok} !== {m_idok, m_ddok}) begin
        errors++; $display("FAIL rnd_data_ok c%0d: got %b%b exp %b%b", c, inst_data_ok, data_data_ok, m_idok, m_ddok); end
      checks++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
        errors++; $display("FAIL rnd_rdata c%0d: got %h/%h exp %h", c, inst_rdata, data_rdata, mem_rdata); end
      checks++; if (outstanding !== 3'(order_q.size())) begin
        errors++; $display("FAIL rnd_outstanding c%0d: got %0d exp %0d", c, outstanding, order_q.size()); end
      checks++; if (err_stray_ok !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", c, err_stray_ok, m_err); end
      model_commit();
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    resetn = 0;
    drive_idle();
    #12;
    test_reset();
    test_single();
    test_priority();
    test_hold();
    test_full();
    test_starve();
    test_stray_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
